entrada_codigo: RTL

- Operator-side front end for the vault: turns the three raw pushbuttons into a 4-digit BCD code and drives the four 7-segment displays.
- Offers the completed code to the vault checker over a valid/ready handshake.
- Sits between the board KEY inputs and the vault control FSM. The vault never sees raw buttons.

---
 rtl/entrada_codigo_pkg.sv | 43 ++++
 rtl/entrada_codigo_debounce.sv | 48 ++++
 rtl/entrada_codigo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/entrada_codigo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// entrada_codigo_pkg : state encoding and 7-segment table for code entry
// Revision: 1.0
// ---------------------------------------------------------------------------
package entrada_codigo_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ENTRADA = 2'd1,
        OFERTA  = 2'd2,
        LIMPA   = 2'd3
    } estado_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba patterns; index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        if (bcd > 4'd9) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_TABLE[bcd];
        end
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/entrada_codigo_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_botao : 2-flop synchronizer, stability counter, press pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao,
    output logic pressionado
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             estavel;
    logic [CNT_W-1:0] contador;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            estavel     <= 1'b1;
            contador    <= '0;
            pressionado <= 1'b0;
        end else begin
            sync1       <= botao;
            sync2       <= sync1;
            pressionado <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == estavel) begin
                contador <= '0;
            end else if (contador == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                contador    <= '0;
                estavel     <= sync2;
                pressionado <= ~sync2;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/entrada_codigo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// entrada_codigo : pushbutton BCD code entry, 7-seg drive, valid/ready offer
// Revision: 1.0
// ---------------------------------------------------------------------------
module entrada_codigo
    import entrada_codigo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int NUM_DIGITOS     = 4
) (
    input  logic        clk_27,
    input  logic        rst_n,
    input  logic        botaoPassarNumero,
    input  logic        botaoPassarDisplay,
    input  logic        botaoConfirmar,
    input  logic        habilita,
    input  logic        limpar,
    input  logic        codigo_pronto,
    output logic [15:0] codigo,
    output logic        codigo_valido,
    output logic [1:0]  digito_sel,
    output logic [6:0]  display1,
    output logic [6:0]  display2,
    output logic [6:0]  display3,
    output logic [6:0]  display4
);

    localparam logic [1:0] SEL_MAX = 2'(NUM_DIGITOS - 1);

    estado_t                     estado;
    logic [NUM_DIGITOS-1:0][3:0] digitos;       // index 0 is digit1
    logic [NUM_DIGITOS-1:0][3:0] digitos_upd;
    logic [1:0]                  sel_upd;
    logic                        ev_numero;
    logic                        ev_display;
    logic                        ev_confirmar;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_numero (
        .clk(clk_27), .rst_n(rst_n), .botao(botaoPassarNumero), .pressionado(ev_numero)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_display (
        .clk(clk_27), .rst_n(rst_n), .botao(botaoPassarDisplay), .pressionado(ev_display)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirmar (
        .clk(clk_27), .rst_n(rst_n), .botao(botaoConfirmar), .pressionado(ev_confirmar)
    );

    // Increment uses the old selection; the advance follows in the same cycle.
    always_comb begin
        digitos_upd = digitos;
        sel_upd     = digito_sel;
        if (ev_numero) begin
            digitos_upd[digito_sel] = (digitos[digito_sel] == 4'd9) ? 4'd0
                                                                     : digitos[digito_sel] + 4'd1;
        end
        if (ev_display) begin
            sel_upd = (digito_sel == SEL_MAX) ? 2'd0 : digito_sel + 2'd1;
        end
    end

    always_ff @(posedge clk_27) begin
        if (!rst_n) begin
            estado        <= OCIOSO;
            digitos       <= '0;
            digito_sel    <= '0;
            codigo        <= '0;
            codigo_valido <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (habilita) begin
                        estado     <= ENTRADA;
                        digitos    <= '0;
                        digito_sel <= '0;
                    end
                end
                ENTRADA: begin
                    if (limpar) begin
                        estado     <= LIMPA;
                        digitos    <= '0;
                        digito_sel <= '0;
                    end else if (!habilita) begin
                        estado <= OCIOSO;
                    end else begin
                        digitos    <= digitos_upd;
                        digito_sel <= sel_upd;
                        if (ev_confirmar) begin
                            codigo        <= {digitos_upd[0], digitos_upd[1],
                                              digitos_upd[2], digitos_upd[3]};
                            codigo_valido <= 1'b1;
                            estado        <= OFERTA;
                        end
                    end
                end
                OFERTA: begin
                    // Abort and completed transfer both leave through LIMPA.
                    if (limpar || codigo_pronto) begin
                        estado        <= LIMPA;
                        digitos       <= '0;
                        digito_sel    <= '0;
                        codigo_valido <= 1'b0;
                    end else if (!habilita) begin
                        estado        <= OCIOSO;
                        codigo_valido <= 1'b0;
                    end
                end
                LIMPA: begin
                    digitos       <= '0;
                    digito_sel    <= '0;
                    codigo_valido <= 1'b0;
                    if (!limpar) begin
                        estado <= habilita ? ENTRADA : OCIOSO;
                    end
                end
                default: begin
                    estado        <= OCIOSO;
                    codigo_valido <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_27) begin
        if (!rst_n || estado == OCIOSO) begin
            display1 <= SEG_BLANK;
            display2 <= SEG_BLANK;
            display3 <= SEG_BLANK;
            display4 <= SEG_BLANK;
        end else begin
            display1 <= seg7(digitos[0]);
            display2 <= seg7(digitos[1]);
            display3 <= seg7(digitos[2]);
            display4 <= seg7(digitos[3]);
        end
    end

endmodule

`default_nettype wire
